// File: rtl/dc_bus_arb.sv
`timescale 1ns/1ps
// dc_bus_arb: round-robin arbiter and transaction sequencer in front of the
// D13 PIO bus interface. One requester at a time owns the command/data port.
// Its command is latched at grant and start is held high until done or timeout.
// The requester then gets a one-cycle ack, and start is kept low long enough
// for the bus interface to see the next rising edge.
module dc_bus_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023,
    parameter int GAP     = 2
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic [NREQ-1:0]   I_REQ,
    input  logic [NREQ-1:0]   I_REQ_READ,
    input  logic [NREQ*8-1:0] I_REQ_CMD,
    input  logic [NREQ*6-1:0] I_REQ_WORDS,
    output logic [NREQ-1:0]   O_GNT,
    output logic [NREQ-1:0]   O_ACK,
    output logic              O_ERR,
    output logic              O_BUSY,
    output logic              O_START,
    output logic              O_READ,
    output logic              O_WRITE,
    output logic [7:0]        O_CMD,
    output logic [5:0]        O_WORDS,
    input  logic              I_DONE
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    localparam int GW = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_gnt;
    logic [7:0]      win_cmd;
    logic [5:0]      win_words;
    logic            win_read;
    logic            wait_exit;

    // Requester index k places after base, wrapping modulo NREQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Pick the first requester after the last winner; the last winner is searched last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_vld && I_REQ[rr_idx(ptr, k)]) begin
                win_vld = 1'b1;
                win_idx = rr_idx(ptr, k);
            end
        end
    end

    // Winner's one-hot grant and its command slice, ready to be latched at grant.
    always_comb begin
        win_gnt          = '0;
        win_gnt[win_idx] = 1'b1;
        win_cmd          = I_REQ_CMD[int'(win_idx)*8 +: 8];
        win_words        = I_REQ_WORDS[int'(win_idx)*6 +: 6];
        win_read         = I_REQ_READ[win_idx];
    end

    // A transaction ends on done; if no done arrives, it ends on the last timeout count.
    // A done that arrives on the terminal count still counts as a clean completion.
    assign wait_exit = I_DONE || (tmo_cnt == TW'(TIMEOUT - 1));

    // Sequencer: IDLE -> WAIT (start high) -> GAP (start low) -> IDLE, with all outputs registered.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state   <= ST_IDLE;
            ptr     <= PW'(NREQ - 1);
            tmo_cnt <= '0;
            gap_cnt <= '0;
            O_GNT   <= '0;
            O_ACK   <= '0;
            O_ERR   <= 1'b0;
            O_BUSY  <= 1'b0;
            O_START <= 1'b0;
            O_READ  <= 1'b0;
            O_WRITE <= 1'b0;
            O_CMD   <= '0;
            O_WORDS <= '0;
        end else begin
            O_ACK <= '0;
            O_ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state   <= ST_WAIT;
                        ptr     <= win_idx;
                        tmo_cnt <= '0;
                        O_GNT   <= win_gnt;
                        O_BUSY  <= 1'b1;
                        O_START <= 1'b1;
                        O_READ  <= win_read;
                        O_WRITE <= ~win_read;
                        O_CMD   <= win_cmd;
                        O_WORDS <= win_words;
                    end
                end
                ST_WAIT: begin
                    if (wait_exit) begin
                        state   <= ST_GAP;
                        tmo_cnt <= '0;
                        gap_cnt <= '0;
                        O_ACK   <= O_GNT;
                        O_ERR   <= ~I_DONE;
                        O_GNT   <= '0;
                        O_START <= 1'b0;
                        O_READ  <= 1'b0;
                        O_WRITE <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state  <= ST_IDLE;
                        O_BUSY <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    O_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dc_bus_arb.sv
`timescale 1ns/1ps
// tb_dc_bus_arb: directed stimulus with an expectation queue. A monitor pops one
// expected grant or ack whenever the arbiter presents one and compares it.
module tb_dc_bus_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 1023;
    localparam int GAP     = 2;

    logic        I_CLK = 1'b0;
    logic        I_RST = 1'b1;
    logic [3:0]  I_REQ;
    logic [3:0]  I_REQ_READ;
    logic [31:0] I_REQ_CMD;
    logic [23:0] I_REQ_WORDS;
    logic        I_DONE;
    logic [3:0]  O_GNT;
    logic [3:0]  O_ACK;
    logic        O_ERR;
    logic        O_BUSY;
    logic        O_START;
    logic        O_READ;
    logic        O_WRITE;
    logic [7:0]  O_CMD;
    logic [5:0]  O_WORDS;

    dc_bus_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_REQ(I_REQ), .I_REQ_READ(I_REQ_READ),
        .I_REQ_CMD(I_REQ_CMD), .I_REQ_WORDS(I_REQ_WORDS), .O_GNT(O_GNT),
        .O_ACK(O_ACK), .O_ERR(O_ERR), .O_BUSY(O_BUSY), .O_START(O_START),
        .O_READ(O_READ), .O_WRITE(O_WRITE), .O_CMD(O_CMD), .O_WORDS(O_WORDS),
        .I_DONE(I_DONE)
    );

    // 50 MHz
    always #10 I_CLK = ~I_CLK;

    typedef struct {
        bit         is_ack;
        logic [3:0] vec;
        logic [7:0] cmd;
        logic [5:0] words;
        bit         rd;
        bit         err;
        int         since_done;  // cycles from the I_DONE cycle, -1 = don't care
        int         since_gnt;   // cycles from the grant cycle, -1 = don't care
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_done = -100;
    int         gnt_cyc = 0;
    logic [3:0] prev_gnt = '0;
    bit         ok;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    // Cycle k is the interval after the k-th rising edge; I_DONE seen at an edge belongs to the previous cycle.
    always @(posedge I_CLK) begin
        cyc++;
        if (I_DONE === 1'b1) last_done = cyc - 1;
    end

    // Monitor: every new grant and every ack/err pulse must match the head of the queue.
    always @(negedge I_CLK) begin
        exp_t e;
        if (!I_RST) begin
            if (O_GNT != 4'b0 && prev_gnt == 4'b0) begin
                gnt_cyc = cyc;
                if (q.size() == 0 || q[0].is_ack) begin
                    chk("unexpected_grant", {28'b0, O_GNT}, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("gnt_vec",   {28'b0, O_GNT},   {28'b0, e.vec});
                    chk("gnt_cmd",   {24'b0, O_CMD},   {24'b0, e.cmd});
                    chk("gnt_words", {26'b0, O_WORDS}, {26'b0, e.words});
                    chk("gnt_read",  {31'b0, O_READ},  {31'b0, e.rd});
                    chk("gnt_write", {31'b0, O_WRITE}, {31'b0, ~e.rd});
                    chk("gnt_start", {31'b0, O_START}, 32'h1);
                    chk("gnt_busy",  {31'b0, O_BUSY},  32'h1);
                    if (e.since_done >= 0) chk("gnt_since_done", cyc - last_done, e.since_done);
                end
            end
            if (O_ACK != 4'b0 || O_ERR) begin
                if (q.size() == 0 || !q[0].is_ack) begin
                    chk("unexpected_ack", {27'b0, O_ERR, O_ACK}, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("ack_vec",   {28'b0, O_ACK},   {28'b0, e.vec});
                    chk("ack_err",   {31'b0, O_ERR},   {31'b0, e.err});
                    chk("ack_cmd",   {24'b0, O_CMD},   {24'b0, e.cmd});
                    chk("ack_start", {31'b0, O_START}, 32'h0);
                    chk("ack_gnt",   {28'b0, O_GNT},   32'h0);
                    chk("ack_rw",    {30'b0, O_READ, O_WRITE}, 32'h0);
                    if (e.since_done >= 0) chk("ack_since_done", cyc - last_done, e.since_done);
                    if (e.since_gnt >= 0)  chk("ack_since_gnt",  cyc - gnt_cyc,   e.since_gnt);
                end
            end
        end
        prev_gnt = O_GNT;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge I_CLK);
    endtask

    task automatic set_req(input int i, input logic [7:0] c, input logic [5:0] w, input logic rd);
        I_REQ_CMD[i*8 +: 8]   = c;
        I_REQ_WORDS[i*6 +: 6] = w;
        I_REQ_READ[i]         = rd;
    endtask

    task automatic exp_gnt(input int w, input logic [7:0] c, input logic [5:0] wd, input bit rd, input int sd);
        exp_t e;
        e.is_ack = 1'b0; e.vec = 4'b0001 << w; e.cmd = c; e.words = wd;
        e.rd = rd; e.err = 1'b0; e.since_done = sd; e.since_gnt = -1;
        q.push_back(e);
    endtask

    task automatic exp_ack(input int w, input logic [7:0] c, input bit err, input int sd, input int sg);
        exp_t e;
        e.is_ack = 1'b1; e.vec = 4'b0001 << w; e.cmd = c; e.words = '0;
        e.rd = 1'b0; e.err = err; e.since_done = sd; e.since_gnt = sg;
        q.push_back(e);
    endtask

    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge I_CLK);
            if (O_GNT != 4'b0) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL wait_gnt: no grant within 50 cycles");
        end
    endtask

    task automatic wait_ack(input int max, output bit got);
        got = 1'b0;
        for (int t = 0; t < max && !got; t++) begin
            @(negedge I_CLK);
            if (O_ACK != 4'b0) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL wait_ack: no ack within %0d cycles", max);
        end
    endtask

    // One-cycle done pulse; returns at the negedge of the ack cycle.
    task automatic pulse_done();
        I_DONE = 1'b1;
        @(negedge I_CLK);
        I_DONE = 1'b0;
    endtask

    initial begin
        I_REQ = '0; I_REQ_READ = '0; I_REQ_CMD = '0; I_REQ_WORDS = '0; I_DONE = 1'b0;
        I_RST = 1'b1;
        tick(3);
        chk("rst_gnt",   {28'b0, O_GNT},   32'h0);
        chk("rst_ack",   {28'b0, O_ACK},   32'h0);
        chk("rst_err",   {31'b0, O_ERR},   32'h0);
        chk("rst_busy",  {31'b0, O_BUSY},  32'h0);
        chk("rst_start", {31'b0, O_START}, 32'h0);
        chk("rst_rw",    {30'b0, O_READ, O_WRITE}, 32'h0);
        chk("rst_cmd",   {24'b0, O_CMD},   32'h0);
        chk("rst_words", {26'b0, O_WORDS}, 32'h0);
        I_RST = 1'b0;
        tick(2);

        // single read request, done 10 cycles after grant
        set_req(0, 8'hB4, 6'd2, 1'b1);
        exp_gnt(0, 8'hB4, 6'd2, 1'b1, -1);
        I_REQ = 4'b0001;
        wait_gnt(ok);
        tick(9);
        exp_ack(0, 8'hB4, 1'b0, 1, 10);
        pulse_done();
        I_REQ = 4'b0000;
        tick(4);

        // command change during WAIT is ignored; done during GAP is ignored
        set_req(1, 8'h20, 6'd5, 1'b0);
        exp_gnt(1, 8'h20, 6'd5, 1'b0, -1);
        I_REQ = 4'b0010;
        wait_gnt(ok);
        tick(2);
        set_req(1, 8'h22, 6'd5, 1'b0);
        tick(3);
        exp_ack(1, 8'h20, 1'b0, 1, 6);
        pulse_done();
        I_REQ  = 4'b0000;
        I_DONE = 1'b1;
        tick(1);
        I_DONE = 1'b0;
        tick(4);

        // timeout abort on requester 2
        set_req(2, 8'h5A, 6'd1, 1'b1);
        exp_gnt(2, 8'h5A, 6'd1, 1'b1, -1);
        I_REQ = 4'b0100;
        wait_gnt(ok);
        exp_ack(2, 8'h5A, 1'b1, -1, TIMEOUT);
        wait_ack(TIMEOUT + 50, ok);
        I_REQ = 4'b0000;
        tick(4);

        // done on the terminal-count cycle is a clean completion
        set_req(3, 8'hC3, 6'd7, 1'b0);
        exp_gnt(3, 8'hC3, 6'd7, 1'b0, -1);
        I_REQ = 4'b1000;
        wait_gnt(ok);
        tick(TIMEOUT - 1);
        exp_ack(3, 8'hC3, 1'b0, 1, TIMEOUT);
        pulse_done();
        I_REQ = 4'b0000;
        tick(4);

        // round robin with all four requesting; grants 4 cycles after each done
        for (int i = 0; i < 4; i++) set_req(i, 8'h10 + 8'(i), 6'(i + 1), i[0]);
        exp_gnt(0, 8'h10, 6'd1, 1'b0, -1);
        I_REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w;
            int nw;
            w  = k % 4;
            nw = (k + 1) % 4;
            wait_gnt(ok);
            tick(3);
            exp_ack(w, 8'h10 + 8'(w), 1'b0, 1, 4);
            pulse_done();
            if (k < 4) begin
                exp_gnt(nw, 8'h10 + 8'(nw), 6'(nw + 1), nw[0], 4);
                I_REQ[w] = 1'b0;
                tick(1);
                I_REQ[w] = 1'b1;
            end else begin
                I_REQ = 4'b0000;
            end
        end
        tick(4);

        // async reset during WAIT: outputs drop at once, no ack, pointer back to NREQ-1
        set_req(1, 8'h77, 6'd3, 1'b1);
        exp_gnt(1, 8'h77, 6'd3, 1'b1, -1);
        I_REQ = 4'b0010;
        wait_gnt(ok);
        tick(2);
        #3 I_RST = 1'b1;
        #1;
        chk("midrst_start", {31'b0, O_START}, 32'h0);
        chk("midrst_gnt",   {28'b0, O_GNT},   32'h0);
        chk("midrst_busy",  {31'b0, O_BUSY},  32'h0);
        I_REQ = 4'b0000;
        @(negedge I_CLK);
        I_RST = 1'b0;
        tick(2);
        set_req(0, 8'h3C, 6'd4, 1'b0);
        set_req(2, 8'h99, 6'd9, 1'b1);
        exp_gnt(0, 8'h3C, 6'd4, 1'b0, -1);
        I_REQ = 4'b0101;
        wait_gnt(ok);
        tick(2);
        exp_ack(0, 8'h3C, 1'b0, 1, 3);
        pulse_done();
        I_REQ = 4'b0000;
        tick(6);

        chk("queue_empty", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
